// File: rtl/serv_seq_pkg.sv
// Shared types for the SERV instruction sequencer: FSM state encoding and counter sizing.
package serv_seq_pkg;

  typedef enum logic [2:0] {
    FETCH,
    RFWAIT,
    INIT,
    HOLD,
    RFWAIT2,
    RUN
  } state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serv_seq_counter.sv
// Pass counter: counts 0..N-1 while enabled, flags the last cycle and returns to 0 after it.
module serv_seq_counter #(
  parameter int N  = 32,
  parameter int CW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_last = i_en & (cnt_q == CW'(N - 1));
  assign o_cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (o_last) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serv_sequencer.sv
// Bit-serial instruction sequencer: fetch, optional INIT pass + HOLD for two-stage ops, then RUN pass.
// Define SERV_SEQ_MDU_EN to add the MDU handshake (i_mdu_op, o_mdu_valid, i_mdu_ready) in HOLD.
module serv_sequencer
  import serv_seq_pkg::*;
#(
  parameter int W        = 1,
  parameter int WITH_CSR = 1,
  localparam int N  = 32 / W,
  localparam int CW = cnt_width(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ibus_ack,
  output logic          o_ibus_cyc,
  input  logic          i_rf_ready,
  output logic          o_rf_rreq,
  output logic          o_rf_wreq,
  input  logic          i_two_stage,
  input  logic          i_mem_op,
  input  logic          i_shift_op,
  input  logic          i_branch_op,
  input  logic          i_take_branch,
  input  logic          i_misalign,
  input  logic          i_new_irq,
  input  logic          i_e_op,
  output logic          o_dbus_cyc,
  input  logic          i_dbus_ack,
  input  logic          i_sh_done,
`ifdef SERV_SEQ_MDU_EN
  input  logic          i_mdu_op,
  output logic          o_mdu_valid,
  input  logic          i_mdu_ready,
`endif
  output logic          o_init,
  output logic          o_cnt_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_cnt_first,
  output logic          o_cnt_last,
  output logic          o_ctrl_pc_en,
  output logic          o_ctrl_jump,
  output logic          o_ctrl_trap
);

  state_e state_q, state_d;
  logic   jump_q, jump_d;
  logic   trap_q, trap_d;
  logic   csr_en;
  logic   jump_next;

  assign csr_en    = (WITH_CSR != 0);
  assign jump_next = i_branch_op & i_take_branch;

  assign o_init       = (state_q == INIT);
  assign o_cnt_en     = (state_q == INIT) | (state_q == RUN);
  assign o_cnt_first  = o_cnt_en & (o_cnt == '0);
  assign o_ctrl_pc_en = o_cnt_en & ~o_init;
  assign o_ctrl_jump  = jump_q;
  assign o_ctrl_trap  = csr_en & (i_e_op | i_new_irq | trap_q);

  serv_seq_counter #(.N(N), .CW(CW)) u_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (o_cnt_en),
    .o_cnt  (o_cnt),
    .o_last (o_cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    jump_d     = jump_q;
    trap_d     = trap_q;
    o_ibus_cyc = 1'b0;
    o_rf_rreq  = 1'b0;
    o_rf_wreq  = 1'b0;
    o_dbus_cyc = 1'b0;
`ifdef SERV_SEQ_MDU_EN
    o_mdu_valid = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        o_ibus_cyc = 1'b1;
        if (i_ibus_ack) begin
          o_rf_rreq = 1'b1;
          state_d   = RFWAIT;
        end
      end
      RFWAIT: begin
        if (i_rf_ready) state_d = (i_two_stage & ~i_new_irq) ? INIT : RUN;
      end
      INIT: begin
        if (o_cnt_last) begin
          jump_d  = jump_next;
          trap_d  = csr_en & i_misalign & (i_mem_op | jump_next);
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A trapping op re-reads the RF (mtvec/epc) instead of touching the bus.
        if (trap_q) begin
          o_rf_rreq = 1'b1;
          state_d   = RFWAIT2;
        end else if (i_mem_op) begin
          o_dbus_cyc = 1'b1;
          if (i_dbus_ack) begin
            o_rf_wreq = 1'b1;
            state_d   = RFWAIT2;
          end
        end else if (i_shift_op) begin
          if (i_sh_done) begin
            o_rf_wreq = 1'b1;
            state_d   = RFWAIT2;
          end
`ifdef SERV_SEQ_MDU_EN
        end else if (i_mdu_op) begin
          o_mdu_valid = 1'b1;
          if (i_mdu_ready) begin
            o_rf_wreq = 1'b1;
            state_d   = RFWAIT2;
          end
`endif
        end else begin
          o_rf_wreq = 1'b1;
          state_d   = RFWAIT2;
        end
      end
      RFWAIT2: begin
        if (i_rf_ready) state_d = RUN;
      end
      RUN: begin
        if (o_cnt_last) begin
          state_d = FETCH;
          trap_d  = 1'b0;
          jump_d  = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FETCH;
      jump_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      jump_q  <= jump_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_serv_sequencer.sv
// Directed bench: three sequencer instances (W=1, W=4, W=8) share stimulus; idle ones are held in reset.
module tb_serv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic ibus_ack, rf_ready, two_stage, mem_op, shift_op, branch_op, take_branch;
  logic misalign, new_irq, e_op, dbus_ack, sh_done;
`ifdef SERV_SEQ_MDU_EN
  logic mdu_op, mdu_ready;
  logic mdu_valid_a, mdu_valid_b, mdu_valid_c;
`endif

  logic ibus_cyc_a, rreq_a, wreq_a, dbus_cyc_a, init_a, cnt_en_a, first_a, last_a, pc_en_a, jump_a, trap_a;
  logic ibus_cyc_b, rreq_b, wreq_b, dbus_cyc_b, init_b, cnt_en_b, first_b, last_b, pc_en_b, jump_b, trap_b;
  logic ibus_cyc_c, rreq_c, wreq_c, dbus_cyc_c, init_c, cnt_en_c, first_c, last_c, pc_en_c, jump_c, trap_c;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;
  int nd, nw, nv, nt;

  serv_sequencer #(.W(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_ibus_ack(ibus_ack), .o_ibus_cyc(ibus_cyc_a),
    .i_rf_ready(rf_ready), .o_rf_rreq(rreq_a), .o_rf_wreq(wreq_a), .i_two_stage(two_stage),
    .i_mem_op(mem_op), .i_shift_op(shift_op), .i_branch_op(branch_op), .i_take_branch(take_branch),
    .i_misalign(misalign), .i_new_irq(new_irq), .i_e_op(e_op), .o_dbus_cyc(dbus_cyc_a),
    .i_dbus_ack(dbus_ack), .i_sh_done(sh_done),
`ifdef SERV_SEQ_MDU_EN
    .i_mdu_op(mdu_op), .o_mdu_valid(mdu_valid_a), .i_mdu_ready(mdu_ready),
`endif
    .o_init(init_a), .o_cnt_en(cnt_en_a), .o_cnt(cnt_a), .o_cnt_first(first_a),
    .o_cnt_last(last_a), .o_ctrl_pc_en(pc_en_a), .o_ctrl_jump(jump_a), .o_ctrl_trap(trap_a)
  );

  serv_sequencer #(.W(4)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_ibus_ack(ibus_ack), .o_ibus_cyc(ibus_cyc_b),
    .i_rf_ready(rf_ready), .o_rf_rreq(rreq_b), .o_rf_wreq(wreq_b), .i_two_stage(two_stage),
    .i_mem_op(mem_op), .i_shift_op(shift_op), .i_branch_op(branch_op), .i_take_branch(take_branch),
    .i_misalign(misalign), .i_new_irq(new_irq), .i_e_op(e_op), .o_dbus_cyc(dbus_cyc_b),
    .i_dbus_ack(dbus_ack), .i_sh_done(sh_done),
`ifdef SERV_SEQ_MDU_EN
    .i_mdu_op(mdu_op), .o_mdu_valid(mdu_valid_b), .i_mdu_ready(mdu_ready),
`endif
    .o_init(init_b), .o_cnt_en(cnt_en_b), .o_cnt(cnt_b), .o_cnt_first(first_b),
    .o_cnt_last(last_b), .o_ctrl_pc_en(pc_en_b), .o_ctrl_jump(jump_b), .o_ctrl_trap(trap_b)
  );

  serv_sequencer #(.W(8)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_ibus_ack(ibus_ack), .o_ibus_cyc(ibus_cyc_c),
    .i_rf_ready(rf_ready), .o_rf_rreq(rreq_c), .o_rf_wreq(wreq_c), .i_two_stage(two_stage),
    .i_mem_op(mem_op), .i_shift_op(shift_op), .i_branch_op(branch_op), .i_take_branch(take_branch),
    .i_misalign(misalign), .i_new_irq(new_irq), .i_e_op(e_op), .o_dbus_cyc(dbus_cyc_c),
    .i_dbus_ack(dbus_ack), .i_sh_done(sh_done),
`ifdef SERV_SEQ_MDU_EN
    .i_mdu_op(mdu_op), .o_mdu_valid(mdu_valid_c), .i_mdu_ready(mdu_ready),
`endif
    .o_init(init_c), .o_cnt_en(cnt_en_c), .o_cnt(cnt_c), .o_cnt_first(first_c),
    .o_cnt_last(last_c), .o_ctrl_pc_en(pc_en_c), .o_ctrl_jump(jump_c), .o_ctrl_trap(trap_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    ibus_ack = 0; rf_ready = 0; two_stage = 0; mem_op = 0; shift_op = 0; branch_op = 0;
    take_branch = 0; misalign = 0; new_irq = 0; e_op = 0; dbus_ack = 0; sh_done = 0;
`ifdef SERV_SEQ_MDU_EN
    mdu_op = 0; mdu_ready = 0;
`endif
    repeat (2) tick();
    chk("rst_cnt", cnt_a, 0);
    chk("rst_cnt_en", cnt_en_a, 0);
    chk("rst_jump", jump_a, 0);
    chk("rst_trap", trap_a, 0);
    chk("rst_rreq", rreq_a, 0);
    chk("rst_wreq", wreq_a, 0);

    // W=1 ALU op: straight to a 32-cycle RUN
    rst_a = 0; #1;
    chk("alu_fetch_cyc", ibus_cyc_a, 1);
    ibus_ack = 1; #1;
    chk("alu_rreq", rreq_a, 1);
    tick(); ibus_ack = 0; rf_ready = 1; #1;
    chk("alu_rfwait_cyc", ibus_cyc_a, 0);
    chk("alu_rfwait_rreq", rreq_a, 0);
    tick(); rf_ready = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("alu_cnt", cnt_a, i);
      chk("alu_last", last_a, (i == 31));
      chk("alu_first", first_a, (i == 0));
      chk("alu_pc_en", pc_en_a, 1);
      tick();
    end
    #1;
    chk("alu_refetch", ibus_cyc_a, 1);
    chk("alu_cnt_idle", cnt_a, 0);
    chk("alu_cnt_en_idle", cnt_en_a, 0);
    rst_a = 1;

    // W=4 taken branch
    rst_b = 0; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1; two_stage = 1; branch_op = 1; take_branch = 1;
    tick(); rf_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("br_init", init_b, 1);
      chk("br_init_cnt", cnt_b, i);
      chk("br_init_pc_en", pc_en_b, 0);
      chk("br_init_last", last_b, (i == 7));
      chk("br_jump_early", jump_b, 0);
      tick();
    end
    #1;
    chk("br_hold_jump", jump_b, 1);
    chk("br_hold_wreq", wreq_b, 1);
    chk("br_hold_trap", trap_b, 0);
    chk("br_hold_dbus", dbus_cyc_b, 0);
    chk("br_hold_cnt_en", cnt_en_b, 0);
    tick(); #1;
    chk("br_rfwait2_wreq", wreq_b, 0);
    rf_ready = 1;
    tick(); rf_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("br_run_cnt", cnt_b, i);
      chk("br_run_pc_en", pc_en_b, 1);
      chk("br_run_jump", jump_b, 1);
      tick();
    end
    #1;
    chk("br_jump_clr", jump_b, 0);
    chk("br_refetch", ibus_cyc_b, 1);
    branch_op = 0; take_branch = 0; rst_b = 1;

    // W=1 misaligned load traps
    rst_a = 0; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1; two_stage = 1; mem_op = 1; misalign = 1;
    tick(); rf_ready = 0;
    repeat (31) tick();
    #1;
    chk("ld_init_last", last_a, 1);
    chk("ld_trap_pre", trap_a, 0);
    tick(); #1;
    chk("ld_hold_trap", trap_a, 1);
    chk("ld_hold_rreq", rreq_a, 1);
    chk("ld_hold_dbus", dbus_cyc_a, 0);
    chk("ld_hold_wreq", wreq_a, 0);
    misalign = 0;
    tick(); #1;
    chk("ld_rfwait2_rreq", rreq_a, 0);
    rf_ready = 1;
    tick(); rf_ready = 0;
    nt = 0; nd = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (trap_a === 1'b1 && cnt_en_a === 1'b1) nt++;
      if (dbus_cyc_a === 1'b1) nd++;
      tick();
    end
    chk("ld_trap_run_cycles", nt, 32);
    chk("ld_run_dbus", nd, 0);
    #1;
    chk("ld_trap_clr", trap_a, 0);
    chk("ld_refetch", ibus_cyc_a, 1);
    rst_a = 1;

    // W=8 store, dbus ack on the 5th request cycle; sh_done must be ignored
    rst_c = 0; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1;
    tick(); rf_ready = 0;
    repeat (3) tick();
    #1;
    chk("st_init_cnt", cnt_c, 3);
    chk("st_init_last", last_c, 1);
    tick();
    sh_done = 1; nd = 0; nw = 0;
    for (int k = 0; k < 12; k++) begin
      dbus_ack = (k == 4);
      #1;
      if (dbus_cyc_c === 1'b1) nd++;
      if (wreq_c === 1'b1) nw++;
      tick();
    end
    chk("st_dbus_cycles", nd, 5);
    chk("st_wreq_pulses", nw, 1);
    dbus_ack = 0; sh_done = 0; rf_ready = 1;
    tick(); rf_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_run_cnt", cnt_c, i);
      tick();
    end
    #1;
    chk("st_refetch", ibus_cyc_c, 1);

    // W=8 shift: dbus_ack held high must not complete it
    mem_op = 0; shift_op = 1; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1;
    tick(); rf_ready = 0;
    repeat (4) tick();
    dbus_ack = 1; nd = 0; nw = 0;
    for (int k = 0; k < 6; k++) begin
      sh_done = (k == 3);
      #1;
      if (dbus_cyc_c === 1'b1) nd++;
      if (wreq_c === 1'b1) nw++;
      tick();
    end
    chk("sh_wreq_pulses", nw, 1);
    chk("sh_dbus_cycles", nd, 0);
    e_op = 1; #1;
    chk("sh_e_op_trap", trap_c, 1);
    e_op = 0; shift_op = 0; dbus_ack = 0; sh_done = 0;
    rst_c = 1; #1; rst_c = 0;

    // Pending interrupt skips INIT even for a two-stage op
    ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1; new_irq = 1;
    tick(); rf_ready = 0; #1;
    chk("irq_no_init", init_c, 0);
    chk("irq_run", cnt_en_c, 1);
    chk("irq_trap", trap_c, 1);
    new_irq = 0;
    repeat (4) tick();
    #1;
    chk("irq_refetch", ibus_cyc_c, 1);
    rst_c = 1;

    // Reset mid-INIT on W=1
    rst_a = 0; shift_op = 1; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1;
    tick(); rf_ready = 0;
    repeat (3) tick();
    #1;
    chk("mid_cnt3", cnt_a, 3);
    chk("mid_init", init_a, 1);
    rst_a = 1; #1;
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_cnt_en", cnt_en_a, 0);
    sh_done = 1; nw = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (wreq_a === 1'b1 || rreq_a === 1'b1) nw++;
      tick();
    end
    chk("mid_rst_pulses", nw, 0);
    sh_done = 0; shift_op = 0;
    rst_a = 0; #1;
    chk("mid_fetch", ibus_cyc_a, 1);
    tick(); #1;
    chk("mid_fetch_hold", ibus_cyc_a, 1);

`ifdef SERV_SEQ_MDU_EN
    // W=1 MDU op, ready on the 10th valid cycle
    mdu_op = 1; ibus_ack = 1;
    tick(); ibus_ack = 0; rf_ready = 1;
    tick(); rf_ready = 0;
    repeat (32) tick();
    nv = 0; nw = 0;
    for (int k = 0; k < 14; k++) begin
      mdu_ready = (k == 9);
      #1;
      if (mdu_valid_a === 1'b1) nv++;
      if (wreq_a === 1'b1) nw++;
      tick();
    end
    chk("mdu_valid_cycles", nv, 10);
    chk("mdu_wreq_pulses", nw, 1);
    mdu_op = 0; mdu_ready = 0;
`endif
    two_stage = 0; rst_a = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_sequencer.md
SERV_SEQUENCER -- requirements
Module: serv_sequencer

Interface
REQ-001 SHALL have parameter W, default 1, datapath bits processed per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter WITH_CSR, default 1, enabling trap generation; 0 forces o_ctrl_trap low.
REQ-003 SHALL derive localparams N = 32/W (cycles per pass) and CW = max(1, log2 N).
REQ-004 SHALL use one clock; reset is asynchronous and active-high:
- i_clk, input, 1: clock.
- i_rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL expose these ports:
- i_ibus_ack, input, 1: instruction fetched.
- o_ibus_cyc, output, 1: instruction fetch request.
- i_rf_ready, input, 1: RF ready; starts a pass.
- o_rf_rreq, output, 1: one-cycle RF read request.
- o_rf_wreq, output, 1: one-cycle RF write request.
- i_two_stage, input, 1: decoded slt/mem/branch/shift.
- i_mem_op, i_shift_op, i_branch_op, inputs, 1 each: op class.
- i_take_branch, input, 1: branch condition; valid on the last INIT cycle.
- i_misalign, input, 1: misaligned target or address.
- i_new_irq, input, 1: pending interrupt.
- i_e_op, input, 1: ecall/ebreak.
- o_dbus_cyc, output, 1: data bus request.
- i_dbus_ack, input, 1: data bus done.
- i_sh_done, input, 1: shifter finished.
- o_init, output, 1: high during INIT.
- o_cnt_en, output, 1: pass active.
- o_cnt, output, CW: cycle index within the pass.
- o_cnt_first, output, 1: o_cnt==0 and o_cnt_en.
- o_cnt_last, output, 1: o_cnt==N-1 and o_cnt_en.
- o_ctrl_pc_en, output, 1: PC update enable.
- o_ctrl_jump, output, 1: registered branch taken.
- o_ctrl_trap, output, 1: trap in progress.

Function
REQ-006 SHALL implement states FETCH, RFWAIT, INIT, HOLD, RFWAIT2 and RUN.
REQ-007 FETCH SHALL hold o_ibus_cyc=1; on i_ibus_ack it pulses o_rf_rreq and goes to RFWAIT.
REQ-008 RFWAIT SHALL go on i_rf_ready to INIT if i_two_stage & !i_new_irq, else to RUN.
REQ-009 INIT and RUN SHALL each last exactly N cycles with o_cnt counting 0..N-1; o_cnt SHALL be 0 outside a pass.
REQ-010 At INIT o_cnt_last, the block SHALL register o_ctrl_jump = i_branch_op & i_take_branch and trap_r = WITH_CSR & i_misalign & (i_mem_op | o_ctrl_jump_next), then enter HOLD.
REQ-011 HOLD SHALL behave as follows:
- If trap_r: pulse o_rf_rreq and enter RFWAIT2.
- Else if mem: assert o_dbus_cyc until i_dbus_ack.
- Else if shift: wait for i_sh_done.
- Then pulse o_rf_wreq and enter RFWAIT2.
REQ-012 RFWAIT2 SHALL go on i_rf_ready to RUN.
REQ-013 On RUN o_cnt_last the block SHALL return to FETCH, clear trap_r and clear o_ctrl_jump.
REQ-014 o_ctrl_pc_en SHALL equal o_cnt_en & !o_init.
REQ-015 o_ctrl_trap SHALL equal WITH_CSR & (i_e_op | i_new_irq | trap_r).
REQ-016 i_rf_ready SHALL be ignored outside RFWAIT/RFWAIT2; i_ibus_ack SHALL be ignored outside FETCH.
REQ-017 If i_dbus_ack and i_sh_done are asserted in the same cycle, only the signal matching the op class SHALL count.

Reset
REQ-018 On reset the block SHALL enter FETCH; o_ibus_cyc asserts on the first cycle after deassertion.
REQ-019 Reset values SHALL be: o_cnt=0, trap_r=0, o_ctrl_jump=0, all pulses 0.
REQ-020 Reset mid-pass SHALL abort immediately with no further rreq/wreq pulse.

Configuration
REQ-021 With SERV_SEQ_MDU_EN defined, the block SHALL add ports i_mdu_op (input, 1), o_mdu_valid (output, 1) and i_mdu_ready (input, 1).
REQ-022 With SERV_SEQ_MDU_EN defined, an MDU op in HOLD SHALL hold o_mdu_valid until i_mdu_ready, then pulse o_rf_wreq.
REQ-023 Without SERV_SEQ_MDU_EN, the MDU ports and logic SHALL be absent.

Structure
REQ-024 Package serv_seq_pkg SHALL hold the state enum and a cnt-width function.
REQ-025 The pass counter SHALL be sub-module serv_seq_counter (start, N-cycle run, last flag).

Verification
REQ-026 W=1, ALU op: ack, then rf_ready -> RUN of 32 cycles, o_cnt_last at cnt 31, o_ibus_cyc 1 cycle later.
REQ-027 W=4, taken branch, no misalign: INIT of 8 cycles, o_ctrl_jump=1, wreq pulse, RUN of 8 cycles.
REQ-028 W=1, load with i_misalign=1: no o_dbus_cyc, rreq pulse, o_ctrl_trap=1 throughout RUN.
REQ-029 W=8, store with dbus ack after 5 cycles: o_dbus_cyc high exactly 5 cycles, then one wreq.
REQ-030 Reset asserted at INIT cnt=3: o_cnt=0 at once, FETCH after release.
REQ-031 With SERV_SEQ_MDU_EN, i_mdu_ready after 10 cycles: o_mdu_valid high 10 cycles, then wreq.
